// File: rtl/vpcie_pkg.sv
// Shared definitions for the vpcie message transmit path.
//   - header geometry (length on the wire and byte offset of every field)
//   - payload buffer depth and credit counter width defaults
//   - transmit FSM state encoding
//   - msg_hdr_t: the latched header, and hdr_byte(): picks one wire byte of it
package vpcie_pkg;

    localparam int HDR_BYTES   = 17;
    localparam int MAX_PAYLOAD = 4096;
    localparam int CREDIT_W    = 8;

    // Byte offsets of each header field on the wire; multi-byte fields are LSB first.
    localparam int HDR_OFF_OP    = 0;
    localparam int HDR_OFF_BAR   = 1;
    localparam int HDR_OFF_WIDTH = 2;
    localparam int HDR_OFF_ADDR  = 3;
    localparam int HDR_OFF_SIZE  = 11;
    localparam int HDR_OFF_WDATA = 13;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_CRED = 3'd2,
        ST_HDR       = 3'd3,
        ST_PAYLOAD   = 3'd4
    } tx_state_e;

    typedef struct packed {
        logic [7:0]  op;
        logic [7:0]  bar;
        logic [7:0]  width;
        logic [63:0] addr;
        logic [15:0] size;
        logic [31:0] word_data;
    } msg_hdr_t;

    // Lay the header out exactly as it appears on the wire, then pick byte idx.
    function automatic logic [7:0] hdr_byte(input msg_hdr_t h, input logic [4:0] idx);
        logic [HDR_BYTES*8-1:0] wire_img;
        logic [7:0]             bit_off;
        wire_img = '0;
        wire_img[HDR_OFF_OP*8    +: 8]  = h.op;
        wire_img[HDR_OFF_BAR*8   +: 8]  = h.bar;
        wire_img[HDR_OFF_WIDTH*8 +: 8]  = h.width;
        wire_img[HDR_OFF_ADDR*8  +: 64] = h.addr;
        wire_img[HDR_OFF_SIZE*8  +: 16] = h.size;
        wire_img[HDR_OFF_WDATA*8 +: 32] = h.word_data;
        bit_off = {idx, 3'b000};
        return wire_img[bit_off +: 8];
    endfunction

endpackage

// File: rtl/vpcie_tx_buf.sv
// Payload byte buffer: simple dual-port RAM, one write port and one read port
// with a registered read. rd_data holds its value while rd_en is low, which the
// transmitter relies on to keep a stalled output byte stable.
//   clk      : clock
//   wr_en    : write strobe, wr_addr/wr_data : write port
//   rd_en    : read strobe,  rd_addr         : read address
//   rd_data  : byte at rd_addr, valid the cycle after rd_en
module vpcie_tx_buf #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/vpcie_msg_tx.sv
// Transmit side of the vpcie message channel.
// Accepts a header plus `size` payload bytes, buffers the payload, then waits
// for a host credit and serialises the 17-byte header followed by the payload
// onto a byte stream toward the host bridge.
// Ports:
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   hdr_valid_i/hdr_ready_o      : header handshake (op/bar/width/addr/size/word_data)
//   pl_valid_i/pl_data_i/pl_ready_o : payload byte handshake
//   credit_i                     : +1 host credit per cycle high
//   tx_valid_o/tx_data_o/tx_last_o/tx_ready_i : output byte stream
//   msg_sent_o                   : pulse the cycle after the final byte handshake
//   err_o                        : pulse when a header with size > MAX_PAYLOAD is rejected
//   credits_o                    : current credit count
// All handshakes: a transfer happens on a rising edge where valid and ready are
// both high; a source holding valid keeps its data stable until that edge.
module vpcie_msg_tx #(
    parameter int MAX_PAYLOAD = vpcie_pkg::MAX_PAYLOAD,
    parameter int CREDIT_W    = vpcie_pkg::CREDIT_W,
    parameter int HDR_BYTES   = vpcie_pkg::HDR_BYTES
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                hdr_valid_i,
    output logic                hdr_ready_o,
    input  logic [7:0]          op_i,
    input  logic [7:0]          bar_i,
    input  logic [7:0]          width_i,
    input  logic [63:0]         addr_i,
    input  logic [15:0]         size_i,
    input  logic [31:0]         word_data_i,
    input  logic                pl_valid_i,
    input  logic [7:0]          pl_data_i,
    output logic                pl_ready_o,
    input  logic                credit_i,
    output logic                tx_valid_o,
    output logic [7:0]          tx_data_o,
    output logic                tx_last_o,
    input  logic                tx_ready_i,
    output logic                msg_sent_o,
    output logic                err_o,
    output logic [CREDIT_W-1:0] credits_o
);

    import vpcie_pkg::*;

    localparam int                  AW       = $clog2(MAX_PAYLOAD);
    localparam logic [16:0]         MAX_SIZE = 17'(MAX_PAYLOAD);
    localparam logic [4:0]          LAST_IDX = 5'(HDR_BYTES - 1);
    localparam logic [CREDIT_W-1:0] CRED_MAX = '1;

    tx_state_e             state;
    msg_hdr_t              hdr;
    logic [4:0]            idx;
    // 17-bit counters so that size == MAX_PAYLOAD never wraps.
    logic [16:0]           wr_ptr;
    logic [16:0]           pl_cnt;
    logic [CREDIT_W-1:0]   credits;
    logic                  msg_sent;
    logic                  err;

    logic [16:0]           size_ext;
    logic [16:0]           size_m1;
    logic                  cred_take;
    logic                  pl_last;
    logic                  buf_wr_en;
    logic                  buf_rd_en;
    logic [AW-1:0]         buf_rd_addr;
    logic [7:0]            buf_q;

    assign size_ext  = {1'b0, hdr.size};
    assign size_m1   = size_ext - 17'd1;
    assign cred_take = (state == ST_WAIT_CRED) && (credits != '0);
    assign pl_last   = (pl_cnt == size_m1);

    // Prefetch: byte 0 is read while the credit is taken, and byte k+1 is read
    // on the handshake of byte k, so buf_q always shows the byte on the wire.
    assign buf_wr_en   = (state == ST_LOAD) && pl_valid_i;
    assign buf_rd_en   = (cred_take && (size_ext != '0)) ||
                         ((state == ST_PAYLOAD) && tx_ready_i && !pl_last);
    assign buf_rd_addr = cred_take ? '0 : (pl_cnt[AW-1:0] + AW'(1));

    vpcie_tx_buf #(
        .DEPTH (MAX_PAYLOAD),
        .AW    (AW)
    ) u_buf (
        .clk     (clk_i),
        .wr_en   (buf_wr_en),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (pl_data_i),
        .rd_en   (buf_rd_en),
        .rd_addr (buf_rd_addr),
        .rd_data (buf_q)
    );

    // Outputs are decoded from registered state only; hdr_ready is also held
    // low while reset is asserted.
    assign hdr_ready_o = (state == ST_IDLE) && !rst_i;
    assign pl_ready_o  = (state == ST_LOAD);
    assign tx_valid_o  = (state == ST_HDR) || (state == ST_PAYLOAD);
    assign tx_last_o   = ((state == ST_HDR) && (idx == LAST_IDX) && (size_ext == '0)) ||
                         ((state == ST_PAYLOAD) && pl_last);
    assign msg_sent_o  = msg_sent;
    assign err_o       = err;
    assign credits_o   = credits;

    always_comb begin
        tx_data_o = '0;
        if (state == ST_HDR) begin
            tx_data_o = hdr_byte(hdr, idx);
        end else if (state == ST_PAYLOAD) begin
            tx_data_o = buf_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            hdr      <= '0;
            idx      <= '0;
            wr_ptr   <= '0;
            pl_cnt   <= '0;
            credits  <= '0;
            msg_sent <= 1'b0;
            err      <= 1'b0;
        end else begin
            msg_sent <= 1'b0;
            err      <= 1'b0;

            // Simultaneous grant and consume cancel out; increment saturates.
            if (credit_i && !cred_take) begin
                if (credits != CRED_MAX) begin
                    credits <= credits + 1'b1;
                end
            end else if (!credit_i && cred_take) begin
                credits <= credits - 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (hdr_valid_i) begin
                        if ({1'b0, size_i} > MAX_SIZE) begin
                            err <= 1'b1;
                        end else begin
                            hdr.op        <= op_i;
                            hdr.bar       <= bar_i;
                            hdr.width     <= width_i;
                            hdr.addr      <= addr_i;
                            hdr.size      <= size_i;
                            hdr.word_data <= word_data_i;
                            wr_ptr        <= '0;
                            state         <= (size_i == '0) ? ST_WAIT_CRED : ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (pl_valid_i) begin
                        wr_ptr <= wr_ptr + 17'd1;
                        if (wr_ptr == size_m1) begin
                            state <= ST_WAIT_CRED;
                        end
                    end
                end
                ST_WAIT_CRED: begin
                    if (cred_take) begin
                        idx   <= '0;
                        state <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (tx_ready_i) begin
                        if (idx == LAST_IDX) begin
                            if (size_ext == '0) begin
                                msg_sent <= 1'b1;
                                state    <= ST_IDLE;
                            end else begin
                                pl_cnt <= '0;
                                state  <= ST_PAYLOAD;
                            end
                        end else begin
                            idx <= idx + 5'd1;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (tx_ready_i) begin
                        if (pl_last) begin
                            msg_sent <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            pl_cnt <= pl_cnt + 17'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vpcie_msg_tx.sv
// Bench for vpcie_msg_tx: header/payload drivers, a byte scoreboard of
// {last, data} entries, and one task per scenario.
module tb_vpcie_msg_tx;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        hdr_valid_i = 1'b0;
    logic        hdr_ready_o;
    logic [7:0]  op_i = '0, bar_i = '0, width_i = '0;
    logic [63:0] addr_i = '0;
    logic [15:0] size_i = '0;
    logic [31:0] word_data_i = '0;
    logic        pl_valid_i = 1'b0;
    logic [7:0]  pl_data_i = '0;
    logic        pl_ready_o;
    logic        credit_i = 1'b0;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_last_o;
    logic        tx_ready_i = 1'b0;
    logic        msg_sent_o;
    logic        err_o;
    logic [7:0]  credits_o;

    logic [8:0]  exp_q[$];
    logic [7:0]  pl_bytes[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    vpcie_msg_tx dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .hdr_valid_i (hdr_valid_i),
        .hdr_ready_o (hdr_ready_o),
        .op_i        (op_i),
        .bar_i       (bar_i),
        .width_i     (width_i),
        .addr_i      (addr_i),
        .size_i      (size_i),
        .word_data_i (word_data_i),
        .pl_valid_i  (pl_valid_i),
        .pl_data_i   (pl_data_i),
        .pl_ready_o  (pl_ready_o),
        .credit_i    (credit_i),
        .tx_valid_o  (tx_valid_o),
        .tx_data_o   (tx_data_o),
        .tx_last_o   (tx_last_o),
        .tx_ready_i  (tx_ready_i),
        .msg_sent_o  (msg_sent_o),
        .err_o       (err_o),
        .credits_o   (credits_o)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- drivers ----------------
    task automatic credit_pulse();
        @(posedge clk); #1 credit_i = 1'b1;
        @(posedge clk); #1 credit_i = 1'b0;
    endtask

    // Offers one header; when push is set the expected 17 wire bytes are queued.
    task automatic send_hdr(input logic [7:0] op, input logic [7:0] bar, input logic [7:0] width,
                            input logic [63:0] addr, input logic [15:0] size,
                            input logic [31:0] wd, input bit push);
        bit ok;
        if (push) begin
            exp_q.push_back({1'b0, op});
            exp_q.push_back({1'b0, bar});
            exp_q.push_back({1'b0, width});
            for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, addr[i*8 +: 8]});
            exp_q.push_back({1'b0, size[7:0]});
            exp_q.push_back({1'b0, size[15:8]});
            for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3) && (size == 16'd0), wd[i*8 +: 8]});
        end
        @(posedge clk); #1;
        hdr_valid_i = 1'b1; op_i = op; bar_i = bar; width_i = width;
        addr_i = addr; size_i = size; word_data_i = wd;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (hdr_ready_o) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        hdr_valid_i = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL hdr_accept: hdr_ready_o=%b required 1 within 100 cycles", hdr_ready_o);
        end
    endtask

    // Sends all bytes in pl_bytes; when push is set they are queued as expected output.
    task automatic send_payload(input bit push);
        bit ok;
        for (int b = 0; b < pl_bytes.size(); b++) begin
            if (push) exp_q.push_back({b == pl_bytes.size() - 1, pl_bytes[b]});
            pl_valid_i = 1'b1;
            pl_data_i  = pl_bytes[b];
            ok = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (pl_ready_o) begin ok = 1'b1; break; end
            end
            @(posedge clk); #1;
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL pl_accept: pl_ready_o=%b required 1 at byte %0d", pl_ready_o, b);
                break;
            end
        end
        pl_valid_i = 1'b0;
    endtask

    // Scoreboard: pops and compares every transferred byte, checks that a
    // stalled byte is held, then checks the msg_sent pulse after the last byte.
    task automatic drain(input int budget, input bit toggle, input string name);
        int         cyc;
        bit         stalled;
        logic [8:0] held;
        logic [8:0] exp;
        cyc = 0; stalled = 1'b0; held = '0;
        while (exp_q.size() > 0 && cyc < budget) begin
            @(posedge clk); #1;
            tx_ready_i = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            cyc++;
            if (stalled && tx_valid_o) begin
                checks++;
                if ({tx_last_o, tx_data_o} !== held) begin
                    errors++;
                    $display("FAIL %s_hold: got %h required %h", name, {tx_last_o, tx_data_o}, held);
                end
            end
            stalled = tx_valid_o && !tx_ready_i;
            held    = {tx_last_o, tx_data_o};
            if (tx_valid_o && tx_ready_i) begin
                exp = exp_q.pop_front();
                checks++;
                if ({tx_last_o, tx_data_o} !== exp) begin
                    errors++;
                    $display("FAIL %s_byte: got last=%b data=%h required last=%b data=%h (%0d left)",
                             name, tx_last_o, tx_data_o, exp[8], exp[7:0], exp_q.size());
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d bytes outstanding required 0", name, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
        tx_ready_i = 1'b0;
        checks++;
        if (msg_sent_o !== 1'b1 || hdr_ready_o !== 1'b1 || tx_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: msg_sent=%b hdr_ready=%b tx_valid=%b required 1 1 0",
                     name, msg_sent_o, hdr_ready_o, tx_valid_o);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (hdr_ready_o !== 1'b0 || pl_ready_o !== 1'b0 || tx_valid_o !== 1'b0 ||
            msg_sent_o !== 1'b0 || err_o !== 1'b0 || credits_o !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: hdr_rdy=%b pl_rdy=%b tx_v=%b sent=%b err=%b cred=%0d required all 0",
                     hdr_ready_o, pl_ready_o, tx_valid_o, msg_sent_o, err_o, credits_o);
        end
        rst_i = 1'b0;
        @(negedge clk);
        checks++;
        if (hdr_ready_o !== 1'b1 || credits_o !== 8'd0) begin
            errors++;
            $display("FAIL reset_release: hdr_ready=%b credits=%0d required 1 0", hdr_ready_o, credits_o);
        end
    endtask

    task automatic test_zero_size();
        credit_pulse();
        checks++;
        if (credits_o !== 8'd1) begin
            errors++;
            $display("FAIL zero_credit_in: credits=%0d required 1", credits_o);
        end
        send_hdr(8'h01, 8'h03, 8'h04, 64'h1122334455667788, 16'd0, 32'hDEADBEEF, 1'b1);
        drain(100, 1'b0, "zero");
        checks++;
        if (credits_o !== 8'd0) begin
            errors++;
            $display("FAIL zero_credit_out: credits=%0d required 0", credits_o);
        end
    endtask

    task automatic test_no_credit();
        int seen;
        send_hdr(8'h42, 8'h01, 8'h02, 64'h0000_0000_CAFE_0000, 16'd4, 32'h01020304, 1'b1);
        pl_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_payload(1'b1);
        tx_ready_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx_valid_o) seen++;
        end
        tx_ready_i = 1'b0;
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL nocred_idle: tx_valid cycles=%0d required 0", seen);
        end
        credit_pulse();
        drain(100, 1'b0, "nocred");
        checks++;
        if (credits_o !== 8'd0) begin
            errors++;
            $display("FAIL nocred_credits: credits=%0d required 0", credits_o);
        end
    endtask

    task automatic test_full_buffer();
        credit_pulse();
        send_hdr(8'h7E, 8'h05, 8'h08, 64'hFEDC_BA98_7654_3210, 16'd4096, 32'hA5A5_5A5A, 1'b1);
        pl_bytes.delete();
        for (int i = 0; i < 4096; i++) pl_bytes.push_back(8'($urandom_range(0, 255)));
        send_payload(1'b1);
        drain(20000, 1'b1, "full");
        checks++;
        if (credits_o !== 8'd0) begin
            errors++;
            $display("FAIL full_credits: credits=%0d required 0", credits_o);
        end
    endtask

    task automatic test_oversize();
        int seen;
        credit_pulse();
        send_hdr(8'h10, 8'h00, 8'h04, 64'h1000, 16'd4097, 32'h0, 1'b0);
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL over_err: err_o=%b required 1", err_o);
        end
        @(posedge clk); #1;
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL over_err_pulse: err_o=%b required 0", err_o);
        end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (tx_valid_o || pl_ready_o) seen++;
        end
        checks++;
        if (seen != 0 || credits_o !== 8'd1 || hdr_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL over_quiet: active=%0d credits=%0d hdr_ready=%b required 0 1 1",
                     seen, credits_o, hdr_ready_o);
        end
        send_hdr(8'h11, 8'h02, 8'h01, 64'h2000, 16'd2, 32'h1234_5678, 1'b1);
        pl_bytes = '{8'h5A, 8'hA5};
        send_payload(1'b1);
        drain(100, 1'b0, "after_over");
        checks++;
        if (credits_o !== 8'd0) begin
            errors++;
            $display("FAIL over_credits: credits=%0d required 0", credits_o);
        end
    endtask

    task automatic test_credit_sat();
        @(posedge clk); #1 credit_i = 1'b1;
        repeat (300) @(posedge clk);
        #1 credit_i = 1'b0;
        checks++;
        if (credits_o !== 8'd255) begin
            errors++;
            $display("FAIL sat_value: credits=%0d required 255", credits_o);
        end
        send_hdr(8'h20, 8'h00, 8'h00, 64'h0, 16'd0, 32'h0, 1'b1);
        drain(100, 1'b0, "sat_a");
        checks++;
        if (credits_o !== 8'd254) begin
            errors++;
            $display("FAIL sat_consume: credits=%0d required 254", credits_o);
        end
        // Header accepted: the credit is taken on the next edge, so grant one then.
        send_hdr(8'h21, 8'h01, 8'h01, 64'h1, 16'd0, 32'h1, 1'b1);
        credit_i = 1'b1;
        @(posedge clk); #1 credit_i = 1'b0;
        checks++;
        if (credits_o !== 8'd254) begin
            errors++;
            $display("FAIL sat_same_cycle: credits=%0d required 254", credits_o);
        end
        drain(100, 1'b0, "sat_b");
    endtask

    task automatic test_reset_mid_payload();
        send_hdr(8'h30, 8'h00, 8'h00, 64'h3000, 16'd8, 32'h0, 1'b0);
        pl_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_payload(1'b0);
        tx_ready_i = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++;
        if (tx_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: tx_valid=%b required 1", tx_valid_o);
        end
        @(posedge clk); #1 rst_i = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (tx_valid_o !== 1'b0 || credits_o !== 8'd0 || hdr_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: tx_valid=%b credits=%0d hdr_ready=%b required 0 0 0",
                     tx_valid_o, credits_o, hdr_ready_o);
        end
        rst_i = 1'b0;
        tx_ready_i = 1'b0;
        @(negedge clk);
        checks++;
        if (hdr_ready_o !== 1'b1 || tx_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_release: hdr_ready=%b tx_valid=%b required 1 0", hdr_ready_o, tx_valid_o);
        end
        credit_pulse();
        send_hdr(8'h31, 8'h09, 8'h02, 64'h3100, 16'd1, 32'h0BAD_F00D, 1'b1);
        pl_bytes = '{8'hE7};
        send_payload(1'b1);
        drain(100, 1'b0, "post_rst");
    endtask

    initial begin
        test_reset();
        test_zero_size();
        test_no_credit();
        test_full_buffer();
        test_oversize();
        test_credit_sat();
        test_reset_mid_payload();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
